// File: rtl/rv16_pkg.sv
// rv16_pkg: shared constants and types for the RV16 core.
// Register addresses, data width and writeback source encodings.
package rv16_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    SRC_ALU,
    SRC_LSU,
    SRC_MDU
  } wb_src_e;

endpackage

// File: rtl/rv16_wb_scoreboard.sv
// rv16_wb_scoreboard: busy bits for registers owned by long-latency units.
// Set by issue, cleared by LSU/MDU writeback; set wins a same-cycle clash.
module rv16_wb_scoreboard
  import rv16_pkg::*;
#(
  parameter int NREGS = rv16_pkg::NREGS
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  input  logic      clr_valid,
  input  reg_addr_t clr_rd,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      rd_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_valid)
      busy_d[clr_rd] = 1'b0;
    if (issue_valid)
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
  assign rd_busy  = busy_q[issue_rd];

endmodule

// File: rtl/rv16_writeback_arbiter.sv
// rv16_writeback_arbiter: merges ALU/LSU/MDU results into the regfile port.
// Optional decode bypass of the registered write: RV16_WB_BYPASS_EN.
module rv16_writeback_arbiter
  import rv16_pkg::*;
#(
  parameter int NREGS = rv16_pkg::NREGS,
  parameter int XLEN  = rv16_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_alu_valid,
  input  reg_addr_t       i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  reg_addr_t       i_lsu_rd,
  input  logic [XLEN-1:0] i_lsu_data,
  input  logic            i_mdu_valid,
  output logic            o_mdu_ready,
  input  reg_addr_t       i_mdu_rd,
  input  logic [XLEN-1:0] i_mdu_data,
  input  logic            i_issue_valid,
  input  reg_addr_t       i_issue_rd,
  input  reg_addr_t       i_rs1_addr,
  input  reg_addr_t       i_rs2_addr,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  output logic            o_rd_busy,
  output reg_addr_t       o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_write_enable
`ifdef RV16_WB_BYPASS_EN
  ,
  output logic            o_fwd_rs1_hit,
  output logic            o_fwd_rs2_hit,
  output logic [XLEN-1:0] o_fwd_data
`endif
);

  wb_src_e         pref_q;
  wb_src_e         src;
  logic            sel_mdu;
  logic            lsu_hs;
  logic            mdu_hs;
  logic            acc;
  reg_addr_t       wr_rd;
  logic [XLEN-1:0] wr_data;

  // pref_q only ever holds SRC_LSU or SRC_MDU
  assign sel_mdu = i_mdu_valid
                && (!i_lsu_valid || pref_q == SRC_MDU);

  assign o_lsu_ready = rst_n && !i_alu_valid && !sel_mdu;
  assign o_mdu_ready = rst_n && !i_alu_valid && sel_mdu;

  assign lsu_hs = i_lsu_valid && o_lsu_ready;
  assign mdu_hs = i_mdu_valid && o_mdu_ready;

  always_comb begin
    src     = SRC_ALU;
    acc     = 1'b0;
    wr_rd   = i_alu_rd;
    wr_data = i_alu_data;
    unique case (1'b1)
      i_alu_valid: acc = 1'b1;
      lsu_hs: begin
        src     = SRC_LSU;
        acc     = 1'b1;
        wr_rd   = i_lsu_rd;
        wr_data = i_lsu_data;
      end
      mdu_hs: begin
        src     = SRC_MDU;
        acc     = 1'b1;
        wr_rd   = i_mdu_rd;
        wr_data = i_mdu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pref_q <= SRC_LSU;
    end else begin
      unique case (src)
        SRC_LSU: pref_q <= SRC_MDU;
        SRC_MDU: pref_q <= SRC_LSU;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_write_enable <= 1'b0;
      o_rd_addr      <= '0;
      o_rd_data      <= '0;
    end else begin
      o_write_enable <= acc && (wr_rd != '0);
      if (acc) begin
        o_rd_addr <= wr_rd;
        o_rd_data <= wr_data;
      end
    end
  end

  rv16_wb_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(i_issue_valid),
    .issue_rd   (i_issue_rd),
    .clr_valid  (lsu_hs || mdu_hs),
    .clr_rd     (lsu_hs ? i_lsu_rd : i_mdu_rd),
    .rs1_addr   (i_rs1_addr),
    .rs2_addr   (i_rs2_addr),
    .rs1_busy   (o_rs1_busy),
    .rs2_busy   (o_rs2_busy),
    .rd_busy    (o_rd_busy)
  );

`ifdef RV16_WB_BYPASS_EN
  assign o_fwd_rs1_hit = o_write_enable
                      && o_rd_addr == i_rs1_addr
                      && i_rs1_addr != '0;
  assign o_fwd_rs2_hit = o_write_enable
                      && o_rd_addr == i_rs2_addr
                      && i_rs2_addr != '0;
  assign o_fwd_data    = o_rd_data;
`endif

endmodule

// File: doc/rv16_writeback_arbiter.md
# rv16_writeback_arbiter

Drives the single write port of the RV16 32 x 32-bit register file. It merges results from the single-cycle ALU, the load/store unit (LSU) and the multi-cycle multiply/divide unit (MDU) into one registered write per cycle. It keeps a busy scoreboard for destinations owned by long-latency units, and it can optionally forward the in-flight write to the decode stage. It sits between the execute units and the register file's write port.

## Interface
Parameters:
- NREGS, 32, number of architectural registers (scoreboard width)
- XLEN, 32, data width

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- i_alu_valid  in  1  ALU result present; cannot be back-pressured
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  XLEN  ALU result
- i_lsu_valid / o_lsu_ready  in / out  1  LSU result handshake
- i_lsu_rd, i_lsu_data  in  5 / XLEN  LSU destination and data
- i_mdu_valid / o_mdu_ready  in / out  1  MDU result handshake
- i_mdu_rd, i_mdu_data  in  5 / XLEN  MDU destination and data
- i_issue_valid  in  1  decode issues an instruction to the LSU or MDU
- i_issue_rd  in  5  destination of that issue
- i_rs1_addr, i_rs2_addr  in  5  decode source registers
- o_rs1_busy, o_rs2_busy  out  1  source awaits a long-latency result
- o_rd_busy  out  1  i_issue_rd is already busy (WAW hazard)
- o_rd_addr  out  5  register-file write address
- o_rd_data  out  XLEN  register-file write data
- o_write_enable  out  1  register-file write strobe

## Operation
- Priority: the ALU always wins. o_lsu_ready and o_mdu_ready are both 0 in any cycle with i_alu_valid=1.
- LSU/MDU round-robin: when the ALU is idle and both are valid, the source granted last time loses. The pointer advances only on a completed handshake (valid && ready).
- Readiness: when the ALU is idle, the selected source's ready=1 and the other's ready=0. Readys are combinational from the valids and the pointer, and do not depend on the source's own valid beyond arbitration.
- Output stage: the accepted result is registered into o_rd_addr/o_rd_data/o_write_enable.
- x0 writes: a result with rd=0 completes its handshake and loads o_rd_addr/o_rd_data, but o_write_enable=0.
- Idle cycles: when no result is accepted, o_write_enable=0 and o_rd_addr/o_rd_data hold their previous values.
- Scoreboard: busy[NREGS-1:0].
  - i_issue_valid with rd≠0 sets busy[rd].
  - A completed LSU or MDU handshake clears busy[rd].
  - The ALU never touches busy.
  - A set and clear to the same register in the same cycle resolves as set.
  - busy[0] is constant 0.
- o_rs1_busy = busy[i_rs1_addr], o_rs2_busy = busy[i_rs2_addr] and o_rd_busy = busy[i_issue_rd]. All three are combinational from current state; a clear in this cycle is not visible until the next cycle.
- Reset mid-operation: the output stage is dropped (o_write_enable=0), busy is cleared, and the pointer returns to LSU-preferred. In-flight handshakes are abandoned.

## Timing
- Reset values:
  - o_write_enable=0, o_rd_addr=0, o_rd_data=0
  - busy=0, so o_rs1_busy=o_rs2_busy=o_rd_busy=0
  - round-robin pointer = LSU preferred
  - o_lsu_ready=o_mdu_ready=0 while rst_n=0
- Latency: a result accepted at edge E appears on the write port after E. The register file commits it at edge E+1. Throughput is one write per cycle.
- The scoreboard updates at the same edge E that accepts the result or issue.
- LSU/MDU must hold valid, rd and data stable until ready; valid must not drop without a handshake.

## Configuration
- RV16_WB_BYPASS_EN
  - Defined: adds outputs o_fwd_rs1_hit, o_fwd_rs2_hit (1 bit each) and o_fwd_data (XLEN).
    - o_fwd_rsN_hit = o_write_enable && o_rd_addr==i_rsN_addr && i_rsN_addr≠0.
    - o_fwd_data = o_rd_data.
    - This lets decode bypass the one-cycle write-port latency.
  - Undefined: these ports do not exist; decode must stall one cycle after a write to a source register.

## Structure
- Shared package rv16_pkg:
  - XLEN and NREGS constants
  - 5-bit reg_addr_t
  - a wb_src_e enum (SRC_ALU, SRC_LSU, SRC_MDU)
- Sub-module rv16_wb_scoreboard: the busy vector, its set/clear logic and the three lookups. Arbitration and the output register stay in the top module.

## Test plan
- Reset with rst_n=0 -> all outputs 0 and both readys 0; after release with LSU and MDU idle -> o_write_enable=0.
- ALU valid rd=5 data=0xDEADBEEF while the LSU is valid -> o_lsu_ready=0; next cycle o_write_enable=1, o_rd_addr=5, o_rd_data=0xDEADBEEF; the LSU is accepted in the following cycle.
- LSU (rd=3) and MDU (rd=4) both valid for 4 cycles with the ALU idle -> writes alternate 3,4 (LSU first after reset), one per cycle.
- Issue rd=7 -> next cycle o_rs1_busy=1 for i_rs1_addr=7. LSU writeback of rd=7 -> busy clears at the handshake edge. Issue rd=7 and MDU completion of rd=7 in the same cycle -> busy stays 1.
- MDU result with rd=0, data=0x1234 -> handshake completes, o_write_enable stays 0; an issue with rd=0 leaves o_rd_busy=0.
- With RV16_WB_BYPASS_EN defined: ALU writes rd=9 data=0x55 and i_rs2_addr=9 -> in the next cycle o_fwd_rs2_hit=1, o_fwd_data=0x55, o_fwd_rs1_hit=0.
